stream_capture_sequencer: RTL

Descriptor-driven AXI4-Stream capture gate; the next generation of the per-channel stream gating logic in the capture system. It accepts a queue of capture descriptors (skip count, burst length, repeat count) and, for each one, discards a number of input samples, then passes one or more length-bounded packets downstream with TLAST framing. It sits between the ADC sample stream and the capture DMA. Between descriptors it drains the input so the converter never stalls.

---
 rtl/stream_capture_sequencer_pkg.sv | 8 +
 rtl/stream_capture_sequencer_cmd_fifo.sv | 47 ++++
 rtl/stream_capture_sequencer.sv | 128 ++++++++++++
 3 files changed

// File: rtl/stream_capture_sequencer_pkg.sv
// stream_capture_sequencer_pkg: shared state encoding and default widths for the capture sequencer
package stream_capture_sequencer_pkg;
  typedef enum logic [1:0] {IDLE, SKIP, PASS} state_e;
  localparam int DATA_W_DEF = 32;
  localparam int LEN_W_DEF = 32;
  localparam int REP_W_DEF = 16;
  localparam int CMD_DEPTH_DEF = 4;
endpackage

// File: rtl/stream_capture_sequencer_cmd_fifo.sv
// capture_cmd_fifo: first-word-fall-through descriptor queue with synchronous flush and occupancy
module capture_cmd_fifo #(
  parameter int W = 80,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       wr_en,
  input  logic [W-1:0]               wr_data,
  input  logic                       rd_en,
  output logic [W-1:0]               rd_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     level
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wp_q, wp_d, rp_q, rp_d;
  logic [AW:0] cnt_q, cnt_d;
  logic push, pop;
  assign full = cnt_q == (AW+1)'(DEPTH);
  assign empty = cnt_q == '0;
  assign level = cnt_q;
  assign rd_data = mem[rp_q];
  always_comb begin
    push = wr_en && !full && !flush;
    pop = rd_en && !empty && !flush;
    wp_d = flush ? '0 : wp_q + AW'(push);
    rp_d = flush ? '0 : rp_q + AW'(pop);
    cnt_d = flush ? '0 : cnt_q + (AW+1)'(push) - (AW+1)'(pop);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      wp_q <= '0;
      rp_q <= '0;
      cnt_q <= '0;
    end else begin
      wp_q <= wp_d;
      rp_q <= rp_d;
      cnt_q <= cnt_d;
    end
  end
  always_ff @(posedge clk) begin
    if (push) mem[wp_q] <= wr_data;
  end
endmodule

// File: rtl/stream_capture_sequencer.sv
// stream_capture_sequencer: descriptor-driven AXI4-Stream gate that skips samples then emits TLAST-framed bursts
module stream_capture_sequencer
  import stream_capture_sequencer_pkg::*;
#(
  parameter int C_S_AXIS_TDATA_WIDTH = DATA_W_DEF,
  parameter int C_LEN_WIDTH = LEN_W_DEF,
  parameter int C_REP_WIDTH = REP_W_DEF,
  parameter int CMD_DEPTH = CMD_DEPTH_DEF
) (
  input  logic                              S_AXIS_ACLK,
  input  logic                              S_AXIS_ARESET,
  input  logic [C_S_AXIS_TDATA_WIDTH-1:0]   S_AXIS_TDATA,
  input  logic [C_S_AXIS_TDATA_WIDTH/8-1:0] S_AXIS_TSTRB,
  input  logic                              S_AXIS_TVALID,
  output logic                              S_AXIS_TREADY,
  input  logic                              S_AXIS_TLAST,
  output logic [C_S_AXIS_TDATA_WIDTH-1:0]   M_AXIS_TDATA,
  output logic [C_S_AXIS_TDATA_WIDTH/8-1:0] M_AXIS_TSTRB,
  output logic                              M_AXIS_TVALID,
  input  logic                              M_AXIS_TREADY,
  output logic                              M_AXIS_TLAST,
  input  logic [C_LEN_WIDTH-1:0]            cmd_skip,
  input  logic [C_LEN_WIDTH-1:0]            cmd_len,
  input  logic [C_REP_WIDTH-1:0]            cmd_repeats,
  input  logic                              cmd_valid,
  output logic                              cmd_ready,
  input  logic                              abort,
  output logic                              busy,
  output logic                              done,
  output logic [$clog2(CMD_DEPTH):0]        cmd_level
);
  localparam int CW = 2*C_LEN_WIDTH + C_REP_WIDTH;
  localparam logic [C_LEN_WIDTH-1:0] LEN_ONE = 1;
  localparam logic [C_REP_WIDTH-1:0] REP_ONE = 1;
  state_e state_q, state_d;
  logic [C_LEN_WIDTH-1:0] skip_q, skip_d, beat_q, beat_d, len_q, len_d, c_skip, c_len;
  logic [C_REP_WIDTH-1:0] rep_q, rep_d, c_rep;
  logic abort_pend_q, abort_pend_d, done_q, done_d;
  logic fifo_rd, fifo_full, fifo_empty, in_pass, xfer, cut;
  logic [CW-1:0] fifo_dout;
  logic unused_tlast;
  assign unused_tlast = S_AXIS_TLAST;
  capture_cmd_fifo #(.W(CW), .DEPTH(CMD_DEPTH)) u_fifo (
    .clk(S_AXIS_ACLK), .rst(S_AXIS_ARESET), .flush(abort),
    .wr_en(cmd_valid && cmd_ready), .wr_data({cmd_skip, cmd_len, cmd_repeats}),
    .rd_en(fifo_rd), .rd_data(fifo_dout), .full(fifo_full), .empty(fifo_empty), .level(cmd_level)
  );
  assign in_pass = state_q == PASS;
  assign xfer = in_pass && S_AXIS_TVALID && M_AXIS_TREADY;
  assign cut = abort || abort_pend_q;
  assign fifo_rd = state_q == IDLE && !fifo_empty && !abort;
  assign M_AXIS_TDATA = S_AXIS_TDATA;
  assign M_AXIS_TSTRB = S_AXIS_TSTRB;
  assign M_AXIS_TVALID = in_pass && S_AXIS_TVALID;
  assign M_AXIS_TLAST = in_pass && (beat_q == LEN_ONE || cut);
  assign S_AXIS_TREADY = in_pass ? M_AXIS_TREADY : 1'b1;
  assign cmd_ready = !fifo_full && !abort;
  assign busy = state_q != IDLE || !fifo_empty;
  assign done = done_q;
  always_comb begin
    {c_skip, c_len, c_rep} = fifo_dout;
    state_d = state_q;
    skip_d = skip_q;
    beat_d = beat_q;
    len_d = len_q;
    rep_d = rep_q;
    abort_pend_d = abort_pend_q;
    done_d = 1'b0;
    if (state_q == IDLE) begin
      if (fifo_rd) begin
        skip_d = c_skip;
        beat_d = c_len;
        len_d = c_len;
        rep_d = c_rep;
        abort_pend_d = 1'b0;
        state_d = c_skip != '0 ? SKIP : (c_len != '0 ? PASS : IDLE);
        done_d = c_skip == '0 && c_len == '0;
      end
    end else if (state_q == SKIP) begin
      if (abort) begin
        state_d = IDLE;
      end else if (S_AXIS_TVALID && skip_q != '0) begin
        skip_d = skip_q - LEN_ONE;
        if (skip_q == LEN_ONE) begin
          state_d = len_q != '0 ? PASS : IDLE;
          done_d = len_q == '0;
        end
      end
    end else if (xfer) begin
      // an abort converts whatever beat moves next into the closing TLAST beat
      if (beat_q != '0) beat_d = beat_q - LEN_ONE;
      if (cut) begin
        state_d = IDLE;
        rep_d = '0;
        abort_pend_d = 1'b0;
      end else if (beat_q == LEN_ONE) begin
        if (rep_q != '0) begin
          beat_d = len_q;
          rep_d = rep_q - REP_ONE;
        end else begin
          state_d = IDLE;
          done_d = 1'b1;
        end
      end
    end else if (abort) begin
      abort_pend_d = 1'b1;
    end
  end
  always_ff @(posedge S_AXIS_ACLK) begin
    if (S_AXIS_ARESET) begin
      state_q <= IDLE;
      skip_q <= '0;
      beat_q <= '0;
      len_q <= '0;
      rep_q <= '0;
      abort_pend_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      skip_q <= skip_d;
      beat_q <= beat_d;
      len_q <= len_d;
      rep_q <= rep_d;
      abort_pend_q <= abort_pend_d;
      done_q <= done_d;
    end
  end
endmodule
